// File: rtl/conditional_subtractor.sv
// Block-serial conditional subtractor: buffers A and A-B while the operand streams in,
// then replays A-B or A depending on the comparator verdict. Optional borrow cross-check: CSUB_BORROW_CHECK_EN.
module conditional_subtractor #(
  parameter int REGISTER_SIZE = 32,
  parameter int NUM_BLOCKS    = 128
) (
  input  logic                     clk_in,
  input  logic                     rst_in,
  input  logic                     valid_in,
  input  logic [REGISTER_SIZE-1:0] block_numA_in,
  input  logic [REGISTER_SIZE-1:0] block_numB_in,
  input  logic [1:0]               comparison_result_in,
  output logic                     ready_out,
  output logic                     valid_out,
  input  logic                     ready_in,
  output logic [REGISTER_SIZE-1:0] block_out,
  output logic                     last_out,
  output logic                     subtracted_out,
  output logic                     error_out
);

  localparam int CW = $clog2(NUM_BLOCKS) + 1;
  localparam int AW = (NUM_BLOCKS > 1) ? $clog2(NUM_BLOCKS) : 1;
  localparam logic [CW-1:0] LAST_IDX = CW'(NUM_BLOCKS - 1);

  typedef enum logic {
    LOAD,
    EMIT
  } state_t;

  state_t                   state_q, state_d;
  logic [CW-1:0]            in_count_q, out_count_q;
  logic                     borrow_q;
  logic                     sel_q;
  logic                     sel_next;
  logic [REGISTER_SIZE:0]   diff;
  logic                     in_fire, in_last, out_fire;
  logic [REGISTER_SIZE-1:0] abuf [NUM_BLOCKS];
  logic [REGISTER_SIZE-1:0] dbuf [NUM_BLOCKS];

  // One extra bit on the subtraction turns its MSB into the outgoing borrow.
  assign diff = {1'b0, block_numA_in} - {1'b0, block_numB_in}
              - {{REGISTER_SIZE{1'b0}}, borrow_q};

  // 10 (A>B) and 11 (A==B) both mean A>=B; 01 and 00 keep A.
  assign sel_next = (comparison_result_in == 2'b10) || (comparison_result_in == 2'b11);

  assign subtracted_out = sel_q;

  // NOTE: every signal gets a default before the case so no path leaves one unassigned (no latches).
  always_comb begin
    state_d   = state_q;
    ready_out = 1'b0;
    valid_out = 1'b0;
    last_out  = 1'b0;
    block_out = '0;
    in_fire   = 1'b0;
    in_last   = 1'b0;
    out_fire  = 1'b0;
    case (state_q)
      LOAD: begin
        ready_out = 1'b1;
        in_fire   = valid_in;
        in_last   = valid_in && (in_count_q == LAST_IDX);
        if (in_last) state_d = EMIT;
      end
      EMIT: begin
        valid_out = 1'b1;
        last_out  = (out_count_q == LAST_IDX);
        block_out = sel_q ? dbuf[out_count_q[AW-1:0]] : abuf[out_count_q[AW-1:0]];
        out_fire  = ready_in;
        if (ready_in && last_out) state_d = LOAD;
      end
      default: state_d = LOAD;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register sees pre-edge values.
  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      state_q     <= LOAD;
      in_count_q  <= '0;
      out_count_q <= '0;
      borrow_q    <= 1'b0;
      sel_q       <= 1'b0;
    end else begin
      state_q <= state_d;
      if (in_fire) begin
        if (in_last) begin
          in_count_q <= '0;
          borrow_q   <= 1'b0;
          sel_q      <= sel_next;
        end else begin
          in_count_q <= in_count_q + 1'b1;
          borrow_q   <= diff[REGISTER_SIZE];
        end
      end
      if (out_fire) begin
        out_count_q <= last_out ? '0 : out_count_q + 1'b1;
      end
    end
  end

  // NOTE: the operand buffers carry no reset; they are always written before being read.
  always_ff @(posedge clk_in) begin
    if (in_fire) begin
      abuf[in_count_q[AW-1:0]] <= block_numA_in;
      dbuf[in_count_q[AW-1:0]] <= diff[REGISTER_SIZE-1:0];
    end
  end

`ifdef CSUB_BORROW_CHECK_EN
  logic error_q;

  // Final borrow clear means A>=B; disagreeing with the comparator is a sticky fault.
  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      error_q <= 1'b0;
    end else if (in_last && ((diff[REGISTER_SIZE] == 1'b0) != sel_next)) begin
      error_q <= 1'b1;
    end
  end

  assign error_out = error_q;
`else
  assign error_out = 1'b0;
`endif

endmodule

// File: tb/tb_conditional_subtractor.sv
// Scoreboard bench for conditional_subtractor (8-bit blocks, 4 blocks per operand):
// the driver pushes model results into a queue, a negedge monitor pops and compares.
module tb_conditional_subtractor;

  localparam int RS = 8;
  localparam int NB = 4;
  localparam int OW = RS * NB;

  logic          clk_in = 1'b0;
  logic          rst_in;
  logic          valid_in;
  logic [RS-1:0] a_blk, b_blk;
  logic [1:0]    cmp;
  logic          ready_out, valid_out, last_out, subtracted_out, error_out;
  logic          ready_in;
  logic [RS-1:0] block_out;
  logic          ready_rand = 1'b1;
  logic          stall = 1'b0;
  bit            rand_mode = 1'b0;

  typedef struct {
    logic [RS-1:0] data;
    logic          last;
    logic          sub;
  } exp_t;

  exp_t exp_q[$];
  int   n_cmp  = 0;
  int   n_fail = 0;

`ifdef CSUB_BORROW_CHECK_EN
  localparam logic EXP_ERR = 1'b1;
`else
  localparam logic EXP_ERR = 1'b0;
`endif

  conditional_subtractor #(.REGISTER_SIZE(RS), .NUM_BLOCKS(NB)) dut (
    .clk_in               (clk_in),
    .rst_in               (rst_in),
    .valid_in             (valid_in),
    .block_numA_in        (a_blk),
    .block_numB_in        (b_blk),
    .comparison_result_in (cmp),
    .ready_out            (ready_out),
    .valid_out            (valid_out),
    .ready_in             (ready_in),
    .block_out            (block_out),
    .last_out             (last_out),
    .subtracted_out       (subtracted_out),
    .error_out            (error_out)
  );

  always #5 clk_in = ~clk_in;

  assign ready_in = ready_rand & ~stall;

  always @(posedge clk_in) begin
    #1;
    ready_rand = rand_mode ? ($urandom_range(0, 3) != 0) : 1'b1;
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference: one conditional reduction step on whole operands.
  function automatic logic [OW-1:0] model(input logic [OW-1:0] a, input logic [OW-1:0] b,
                                          input logic [1:0] c);
    return ((c == 2'b10) || (c == 2'b11)) ? a - b : a;
  endfunction

  always @(negedge clk_in) begin
    if (rst_in && valid_out) begin
      if (exp_q.size() == 0) begin
        n_cmp++;
        n_fail++;
        $display("FAIL unexpected_out: got block %0h expected no output at %0t", block_out, $time);
      end else begin
        check("block_out", block_out, exp_q[0].data);
        check("last_out", last_out, exp_q[0].last);
        check("subtracted_out", subtracted_out, exp_q[0].sub);
        check("ready_out_in_emit", ready_out, 1'b0);
        if (ready_in) void'(exp_q.pop_front());
      end
    end
  end

  task automatic send(input logic [OW-1:0] a, input logic [OW-1:0] b, input logic [1:0] c,
                      input int beats, input int max_gap);
    logic [OW-1:0] r;
    for (int i = 0; i < beats; i++) begin
      int w = 0;
      repeat ($urandom_range(0, max_gap)) begin
        valid_in = 1'b0;
        @(posedge clk_in); #1;
      end
      valid_in = 1'b1;
      a_blk    = a[i*RS +: RS];
      b_blk    = b[i*RS +: RS];
      cmp      = (i == NB - 1) ? c : 2'b00;
      while (!ready_out && w < 1000) begin
        @(posedge clk_in); #1;
        w++;
      end
      if (!ready_out) begin
        n_cmp++;
        n_fail++;
        $display("FAIL ready_timeout: got ready_out 0 expected 1 at %0t", $time);
      end
      @(posedge clk_in); #1;
    end
    valid_in = 1'b0;
    cmp      = 2'b00;
    if (beats == NB) begin
      r = model(a, b, c);
      for (int i = 0; i < NB; i++)
        exp_q.push_back('{data: r[i*RS +: RS], last: (i == NB - 1),
                          sub: ((c == 2'b10) || (c == 2'b11))});
    end
  endtask

  task automatic drain();
    int w = 0;
    while ((exp_q.size() != 0 || !ready_out) && w < 2000) begin
      @(posedge clk_in); #1;
      w++;
    end
    check("drain_queue_empty", exp_q.size(), 0);
    check("drain_valid_out", valid_out, 1'b0);
    check("drain_ready_out", ready_out, 1'b1);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_ready_out"}, ready_out, 1'b1);
    check({tag, "_valid_out"}, valid_out, 1'b0);
    check({tag, "_last_out"}, last_out, 1'b0);
    check({tag, "_subtracted_out"}, subtracted_out, 1'b0);
    check({tag, "_error_out"}, error_out, 1'b0);
    check({tag, "_block_out"}, block_out, '0);
  endtask

  localparam logic [OW-1:0] A_GT = 32'h1000_0005;
  localparam logic [OW-1:0] B_GT = 32'h0100_0007;
  localparam logic [OW-1:0] A_EQ = 32'hDDCC_BBAA;

  initial begin
    rst_in   = 1'b0;
    valid_in = 1'b0;
    a_blk    = '0;
    b_blk    = '0;
    cmp      = 2'b00;
    #12;
    check_reset_outputs("reset");
    @(negedge clk_in) rst_in = 1'b1;
    @(posedge clk_in); #1;

    // A>B, A<B, A==B
    send(A_GT, B_GT, 2'b10, NB, 0);
    drain();
    send(B_GT, A_GT, 2'b01, NB, 0);
    drain();
    send(A_EQ, A_EQ, 2'b11, NB, 0);
    drain();

    // Output stall on block 1 for three cycles
    send(A_GT, B_GT, 2'b10, NB, 0);
    @(posedge clk_in); #1;
    stall = 1'b1;
    repeat (3) @(posedge clk_in);
    #1;
    stall = 1'b0;
    drain();

    // Gaps between input beats
    send(A_GT, B_GT, 2'b10, NB, 3);
    drain();

    // Reset after two beats; only the following operand may appear
    send(A_GT, B_GT, 2'b10, 2, 0);
    rst_in = 1'b0;
    #2;
    check_reset_outputs("midreset");
    @(negedge clk_in) rst_in = 1'b1;
    @(posedge clk_in); #1;
    send(B_GT, A_GT, 2'b01, NB, 0);
    drain();

    // Random operands with consistent comparator verdicts and random backpressure
    rand_mode = 1'b1;
    repeat (40) begin
      logic [OW-1:0] a, b;
      logic [1:0]    c;
      a = OW'($urandom);
      b = ($urandom_range(0, 3) == 0) ? a : OW'($urandom);
      c = (a > b) ? 2'b10 : (a < b) ? 2'b01 : 2'b11;
      send(a, b, c, NB, 2);
    end
    drain();
    rand_mode = 1'b0;
    check("error_after_random", error_out, 1'b0);

    // Comparator contradicts the borrow chain
    send(A_GT, B_GT, 2'b01, NB, 0);
    drain();
    check("error_inconsistent", error_out, EXP_ERR);
    send(B_GT, A_GT, 2'b01, NB, 0);
    drain();
    check("error_sticky", error_out, EXP_ERR);

    rst_in = 1'b0;
    #2;
    check_reset_outputs("final_reset");
    rst_in = 1'b1;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
